// File: rtl/cpu_checker_core_pkg.sv
// Shared constants for the CPU trace-record checker: state codes, format codes
// and the ASCII characters that delimit record fields.
package cpu_checker_core_pkg;

   localparam int unsigned CHAR_W   = 8;
   localparam int unsigned STATE_W  = 4;
   localparam int unsigned STATUS_W = 5;
   localparam int unsigned CNT_W    = 3;
   localparam int unsigned FMT_W    = 2;

   localparam logic [STATE_W-1:0] ST_IDLE   = 4'd0;
   localparam logic [STATE_W-1:0] ST_CARET  = 4'd1;
   localparam logic [STATE_W-1:0] ST_TIME   = 4'd2;
   localparam logic [STATE_W-1:0] ST_AT     = 4'd3;
   localparam logic [STATE_W-1:0] ST_PC     = 4'd4;
   localparam logic [STATE_W-1:0] ST_COLON  = 4'd5;
   localparam logic [STATE_W-1:0] ST_DOLLAR = 4'd6;
   localparam logic [STATE_W-1:0] ST_GRF    = 4'd7;
   localparam logic [STATE_W-1:0] ST_STAR   = 4'd8;
   localparam logic [STATE_W-1:0] ST_ADDR   = 4'd9;
   localparam logic [STATE_W-1:0] ST_PRE_LT = 4'd10;
   localparam logic [STATE_W-1:0] ST_LT     = 4'd11;
   localparam logic [STATE_W-1:0] ST_EQ     = 4'd12;
   localparam logic [STATE_W-1:0] ST_DATA   = 4'd13;
   localparam logic [STATE_W-1:0] ST_DONE   = 4'd14;

   localparam logic [FMT_W-1:0] FMT_NONE = 2'b00;
   localparam logic [FMT_W-1:0] FMT_REG  = 2'b01;
   localparam logic [FMT_W-1:0] FMT_MEM  = 2'b10;

   localparam logic KIND_REG = 1'b0;
   localparam logic KIND_MEM = 1'b1;

   // Counter holds (digits seen - 1), so these are the last legal values.
   localparam logic [CNT_W-1:0] CNT_DEC_LAST = 3'd3;
   localparam logic [CNT_W-1:0] CNT_HEX_LAST = 3'd7;

   localparam logic [CHAR_W-1:0] CH_CARET  = 8'h5E;
   localparam logic [CHAR_W-1:0] CH_AT     = 8'h40;
   localparam logic [CHAR_W-1:0] CH_COLON  = 8'h3A;
   localparam logic [CHAR_W-1:0] CH_DOLLAR = 8'h24;
   localparam logic [CHAR_W-1:0] CH_STAR   = 8'h2A;
   localparam logic [CHAR_W-1:0] CH_LT     = 8'h3C;
   localparam logic [CHAR_W-1:0] CH_EQ     = 8'h3D;
   localparam logic [CHAR_W-1:0] CH_HASH   = 8'h23;
   localparam logic [CHAR_W-1:0] CH_SPACE  = 8'h20;
   localparam logic [CHAR_W-1:0] CH_0      = 8'h30;
   localparam logic [CHAR_W-1:0] CH_9      = 8'h39;
   localparam logic [CHAR_W-1:0] CH_A_LO   = 8'h61;
   localparam logic [CHAR_W-1:0] CH_F_LO   = 8'h66;

   function automatic logic [FMT_W-1:0] kind_to_fmt(input logic kind);
      return (kind == KIND_MEM) ? FMT_MEM : FMT_REG;
   endfunction

endpackage

// File: rtl/cpu_checker_core_char_class.sv
// Combinational character classifier: decimal digit, lowercase hex digit, space.
module cpu_checker_core_char_class
   import cpu_checker_core_pkg::*;
(
   input  logic [7:0] char_i,
   output logic       is_dec_o,
   output logic       is_hex_o,
   output logic       is_space_o
);

   logic is_af;

   assign is_dec_o   = (char_i >= CH_0) && (char_i <= CH_9);
   assign is_af      = (char_i >= CH_A_LO) && (char_i <= CH_F_LO);
   assign is_hex_o   = is_dec_o || is_af;
   assign is_space_o = (char_i == CH_SPACE);

endmodule

// File: rtl/cpu_checker_core.sv
// Streaming parser for register/memory write trace records, one ASCII char per
// clock; flags a complete well-formed record for the cycle after its '#'.
module cpu_checker_core
   import cpu_checker_core_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] char,
   output logic [1:0] format_type,
   output logic [4:0] status
);

   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               kind_q, kind_d;
   logic               is_dec, is_hex, is_space;
   logic               dec_room, hex_room, hex_full;

   cpu_checker_core_char_class u_char_class (
      .char_i     (char),
      .is_dec_o   (is_dec),
      .is_hex_o   (is_hex),
      .is_space_o (is_space)
   );

   assign dec_room = (cnt_q < CNT_DEC_LAST);
   assign hex_room = (cnt_q < CNT_HEX_LAST);
   assign hex_full = (cnt_q == CNT_HEX_LAST);

   // Next-state: anything not explicitly accepted falls back to IDLE.
   always_comb begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      kind_d  = kind_q;
      if (char == CH_CARET) begin
         state_d = ST_CARET;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_CARET: begin
               if (is_dec) begin
                  state_d = ST_TIME;
                  cnt_d   = '0;
               end
            end
            ST_TIME: begin
               if (is_dec && dec_room) begin
                  state_d = ST_TIME;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (char == CH_AT) begin
                  state_d = ST_AT;
               end
            end
            ST_AT: begin
               if (is_hex) begin
                  state_d = ST_PC;
                  cnt_d   = '0;
               end
            end
            ST_PC: begin
               if (is_hex && hex_room) begin
                  state_d = ST_PC;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (char == CH_COLON && hex_full) begin
                  state_d = ST_COLON;
               end
            end
            ST_COLON: begin
               if (is_space) begin
                  state_d = ST_COLON;
               end else if (char == CH_DOLLAR) begin
                  state_d = ST_DOLLAR;
                  kind_d  = KIND_REG;
               end else if (char == CH_STAR) begin
                  state_d = ST_STAR;
                  kind_d  = KIND_MEM;
               end
            end
            ST_DOLLAR: begin
               if (is_dec) begin
                  state_d = ST_GRF;
                  cnt_d   = '0;
               end
            end
            ST_GRF: begin
               if (is_dec && dec_room) begin
                  state_d = ST_GRF;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (is_space) begin
                  state_d = ST_PRE_LT;
               end else if (char == CH_LT) begin
                  state_d = ST_LT;
               end
            end
            ST_STAR: begin
               if (is_hex) begin
                  state_d = ST_ADDR;
                  cnt_d   = '0;
               end
            end
            ST_ADDR: begin
               if (is_hex && hex_room) begin
                  state_d = ST_ADDR;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (is_space && hex_full) begin
                  state_d = ST_PRE_LT;
               end else if (char == CH_LT && hex_full) begin
                  state_d = ST_LT;
               end
            end
            ST_PRE_LT: begin
               if (is_space) begin
                  state_d = ST_PRE_LT;
               end else if (char == CH_LT) begin
                  state_d = ST_LT;
               end
            end
            ST_LT: begin
               if (char == CH_EQ) begin
                  state_d = ST_EQ;
               end
            end
            ST_EQ: begin
               if (is_space) begin
                  state_d = ST_EQ;
               end else if (is_hex) begin
                  state_d = ST_DATA;
                  cnt_d   = '0;
               end
            end
            ST_DATA: begin
               if (is_hex && hex_room) begin
                  state_d = ST_DATA;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else if (char == CH_HASH && hex_full) begin
                  state_d = ST_DONE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         kind_q  <= KIND_REG;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         kind_q  <= kind_d;
      end
   end

   assign format_type = (state_q == ST_DONE) ? kind_to_fmt(kind_q) : FMT_NONE;
   assign status      = STATUS_W'(state_q);

endmodule

// File: tb/tb_cpu_checker_core.sv
// Bench for cpu_checker_core: directed record scenarios plus random records,
// checked against a string-level grammar reference model.
module tb_cpu_checker_core;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] char;
   logic [1:0] format_type;
   logic [4:0] status;

   int         errors = 0;
   int         checks = 0;

   // Reference model: text since the most recent '^' (since reset).
   string      mbuf;
   bit         mact;
   logic [1:0] exp_fmt;
   logic [1:0] obs_fmt;
   logic [4:0] obs_status;

   cpu_checker_core dut (
      .clk         (clk),
      .reset       (reset),
      .char        (char),
      .format_type (format_type),
      .status      (status)
   );

   always #5 clk = ~clk;

   function automatic bit is_d(input byte c);
      return (c >= "0") && (c <= "9");
   endfunction

   function automatic bit is_h(input byte c);
      return is_d(c) || ((c >= "a") && (c <= "f"));
   endfunction

   // Whole-string grammar check: 1 = register record, 2 = memory record, 0 = invalid.
   function automatic logic [1:0] validate(input string s);
      int L;
      int i;
      int n;
      logic [1:0] k;
      L = s.len();
      i = 1;
      if (L == 0 || s[0] != "^") return 2'd0;
      n = 0;
      while (i < L && is_d(s[i])) begin n++; i++; end
      if (n < 1 || n > 4) return 2'd0;
      if (i >= L || s[i] != "@") return 2'd0;
      i++;
      n = 0;
      while (i < L && is_h(s[i])) begin n++; i++; end
      if (n != 8) return 2'd0;
      if (i >= L || s[i] != ":") return 2'd0;
      i++;
      while (i < L && s[i] == " ") i++;
      if (i >= L) return 2'd0;
      if (s[i] == "$") begin
         i++;
         n = 0;
         while (i < L && is_d(s[i])) begin n++; i++; end
         if (n < 1 || n > 4) return 2'd0;
         k = 2'd1;
      end else if (s[i] == "*") begin
         i++;
         n = 0;
         while (i < L && is_h(s[i])) begin n++; i++; end
         if (n != 8) return 2'd0;
         k = 2'd2;
      end else begin
         return 2'd0;
      end
      while (i < L && s[i] == " ") i++;
      if (i + 1 >= L || s[i] != "<" || s[i+1] != "=") return 2'd0;
      i += 2;
      while (i < L && s[i] == " ") i++;
      n = 0;
      while (i < L && is_h(s[i])) begin n++; i++; end
      if (n != 8) return 2'd0;
      if (i != L - 1 || s[i] != "#") return 2'd0;
      return k;
   endfunction

   // One clock: drive char/reset, advance the model, compare outputs.
   task automatic step(input byte c, input bit rst);
      reset = rst;
      char  = c;
      @(posedge clk);
      #1;
      if (rst) begin
         mact = 1'b0;
         mbuf = "";
         exp_fmt = 2'd0;
      end else begin
         if (c == "^") begin
            mact = 1'b1;
            mbuf = "^";
         end else if (mact) begin
            mbuf = $sformatf("%s%c", mbuf, c);
         end
         exp_fmt = (mact && c == "#") ? validate(mbuf) : 2'd0;
      end
      obs_fmt    = format_type;
      obs_status = status;
      checks++;
      if (obs_fmt !== exp_fmt) begin
         errors++;
         $display("FAIL format_type @%0t char=0x%02h: got %b expected %b", $time, c, obs_fmt, exp_fmt);
      end
      checks++;
      if ((obs_status == 5'd14) !== (exp_fmt != 2'd0)) begin
         errors++;
         $display("FAIL status_done @%0t: got status=%0d expected DONE=%0b", $time, obs_status, exp_fmt != 2'd0);
      end
      if (rst) begin
         checks++;
         if (obs_status !== 5'd0) begin
            errors++;
            $display("FAIL reset_status: got %0d expected 0", obs_status);
         end
      end
   endtask

   task automatic send_str(input string s, output int nz, output logic [1:0] last);
      nz   = 0;
      last = 2'd0;
      for (int i = 0; i < s.len(); i++) begin
         step(s[i], 1'b0);
         if (obs_fmt != 2'd0) begin
            nz++;
            last = obs_fmt;
         end
      end
   endtask

   task automatic expect_hits(input string name, input int nz, input logic [1:0] last,
                              input int exp_nz, input logic [1:0] exp_last);
      checks++;
      if (nz !== exp_nz || last !== exp_last) begin
         errors++;
         $display("FAIL %s: got %0d records last=%b expected %0d last=%b", name, nz, last, exp_nz, exp_last);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(8'h5E, 1'b1);
   endtask

   task automatic test_mem_record();
      int nz;
      logic [1:0] last;
      send_str("^1024@000030fc:*89abcdef<=89abcdef#", nz, last);
      expect_hits("mem_record", nz, last, 1, 2'b10);
      checks++;
      if (obs_status !== 5'd14) begin
         errors++;
         $display("FAIL mem_record_status: got %0d expected 14", obs_status);
      end
   endtask

   task automatic test_status_walk();
      string s;
      int walk [7] = '{1, 2, 2, 2, 2, 3, 4};
      int nz;
      logic [1:0] last;
      step(" ", 1'b0);
      checks++;
      if (obs_status !== 5'd0) begin
         errors++;
         $display("FAIL walk_idle: got %0d expected 0", obs_status);
      end
      s = "^7836@000030f4: *00002ffc<=19521025#";
      nz = 0;
      last = 2'd0;
      for (int i = 0; i < s.len(); i++) begin
         step(s[i], 1'b0);
         if (obs_fmt != 2'd0) begin nz++; last = obs_fmt; end
         if (i < 7) begin
            checks++;
            if (obs_status !== 5'(walk[i])) begin
               errors++;
               $display("FAIL walk_%0d: got %0d expected %0d", i, obs_status, walk[i]);
            end
         end
      end
      expect_hits("mem_space_record", nz, last, 1, 2'b10);
   endtask

   task automatic test_reg_record();
      int nz;
      logic [1:0] last;
      send_str("^66@0000301c: $1<=1e1f831e#", nz, last);
      expect_hits("reg_record", nz, last, 1, 2'b01);
   endtask

   task automatic test_negative();
      int nz;
      logic [1:0] last;
      send_str("^12345@000030fc:$1<=1e1f831e#", nz, last);
      expect_hits("neg_time_long", nz, last, 0, 2'b00);
      send_str("^1@0000301C:$1<=1e1f831e#", nz, last);
      expect_hits("neg_upper_hex", nz, last, 0, 2'b00);
      send_str("^1@00003000:$1< =1e1f831e#", nz, last);
      expect_hits("neg_split_le", nz, last, 0, 2'b00);
      send_str("^1@00003000:$1<=1e1f831#", nz, last);
      expect_hits("neg_data_short", nz, last, 0, 2'b00);
      send_str("^1@00003000:$12345<=1e1f831e#", nz, last);
      expect_hits("neg_grf_long", nz, last, 0, 2'b00);
      send_str("^1@00003000:*0000300 <=1e1f831e#", nz, last);
      expect_hits("neg_addr_short", nz, last, 0, 2'b00);
   endtask

   task automatic test_restart();
      int nz;
      logic [1:0] last;
      send_str("^12@0000^1@00003000:$2 <= 00000001#", nz, last);
      expect_hits("restart", nz, last, 1, 2'b01);
   endtask

   task automatic test_back_to_back();
      int nz;
      logic [1:0] last;
      send_str("^9999@ffffffff:*00000000  <=  abcdef01#^0@00000000:$0<=00000000#", nz, last);
      expect_hits("back_to_back", nz, last, 2, 2'b01);
   endtask

   task automatic test_reset_mid_record();
      int nz;
      logic [1:0] last;
      send_str("^5@0000abcd:*0000", nz, last);
      step("1", 1'b1);
      step("#", 1'b1);
      send_str("#^5@0000abcd:*00001234<=deadbeef#", nz, last);
      expect_hits("reset_mid_record", nz, last, 1, 2'b10);
   endtask

   function automatic string gen_rec();
      string hexs;
      string r;
      int n;
      hexs = "0123456789abcdef";
      r = "^";
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) r = $sformatf("%s%c", r, hexs[$urandom_range(0, 9)]);
      r = {r, "@"};
      for (int i = 0; i < 8; i++) r = $sformatf("%s%c", r, hexs[$urandom_range(0, 15)]);
      r = {r, ":"};
      for (int i = $urandom_range(0, 2); i > 0; i--) r = {r, " "};
      if ($urandom_range(0, 1) == 0) begin
         r = {r, "$"};
         n = $urandom_range(1, 4);
         for (int i = 0; i < n; i++) r = $sformatf("%s%c", r, hexs[$urandom_range(0, 9)]);
      end else begin
         r = {r, "*"};
         for (int i = 0; i < 8; i++) r = $sformatf("%s%c", r, hexs[$urandom_range(0, 15)]);
      end
      for (int i = $urandom_range(0, 2); i > 0; i--) r = {r, " "};
      r = {r, "<="};
      for (int i = $urandom_range(0, 2); i > 0; i--) r = {r, " "};
      for (int i = 0; i < 8; i++) r = $sformatf("%s%c", r, hexs[$urandom_range(0, 15)]);
      r = {r, "#"};
      return r;
   endfunction

   task automatic test_random();
      string s;
      string alph;
      int rst_at;
      alph = "^@:$*<=# 09afAG";
      for (int k = 0; k < 80; k++) begin
         s = gen_rec();
         if ($urandom_range(0, 2) == 0) s.putc($urandom_range(0, s.len() - 1), alph[$urandom_range(0, alph.len() - 1)]);
         rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, s.len() - 1) : -1;
         for (int i = 0; i < s.len(); i++) step(s[i], i == rst_at);
         if ($urandom_range(0, 3) == 0) step(alph[$urandom_range(0, alph.len() - 1)], 1'b0);
      end
   endtask

   initial begin
      reset = 1'b1;
      char  = 8'h00;
      mact  = 1'b0;
      mbuf  = "";
      test_reset();
      test_mem_record();
      test_status_walk();
      test_reg_record();
      test_negative();
      test_restart();
      test_back_to_back();
      test_reset_mid_record();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
